// File: rtl/num_entry_pkg.sv
// Shared scancode constants, FSM state encoding and elaboration-time helpers
// for the PS/2 numeric-entry block.
package num_entry_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } digit_t;

  // Main-row digits always decode; keypad digits only when keypad_en is set.
  function automatic digit_t scan_to_digit(input logic [7:0] sc, input logic keypad_en);
    digit_t r;
    r = '0;
    case (sc)
      8'h45: r = '{1'b1, 4'd0};
      8'h16: r = '{1'b1, 4'd1};
      8'h1E: r = '{1'b1, 4'd2};
      8'h26: r = '{1'b1, 4'd3};
      8'h25: r = '{1'b1, 4'd4};
      8'h2E: r = '{1'b1, 4'd5};
      8'h36: r = '{1'b1, 4'd6};
      8'h3D: r = '{1'b1, 4'd7};
      8'h3E: r = '{1'b1, 4'd8};
      8'h46: r = '{1'b1, 4'd9};
      default: r = '0;
    endcase
    if (keypad_en) begin
      case (sc)
        8'h70: r = '{1'b1, 4'd0};
        8'h69: r = '{1'b1, 4'd1};
        8'h72: r = '{1'b1, 4'd2};
        8'h7A: r = '{1'b1, 4'd3};
        8'h6B: r = '{1'b1, 4'd4};
        8'h73: r = '{1'b1, 4'd5};
        8'h74: r = '{1'b1, 4'd6};
        8'h6C: r = '{1'b1, 4'd7};
        8'h75: r = '{1'b1, 4'd8};
        8'h7D: r = '{1'b1, 4'd9};
        default: ;
      endcase
    end
    return r;
  endfunction

  // Four-digit BCD image of a constant, ones digit in [3:0].
  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0]  r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Number of significant decimal digits, never less than one.
  function automatic int unsigned sig_digits(input int unsigned v);
    int unsigned n;
    n = 1;
    if (v >= 10)   n = 2;
    if (v >= 100)  n = 3;
    if (v >= 1000) n = 4;
    return n;
  endfunction

endpackage

// File: rtl/num_entry_fsm_if.sv
// Byte-input / committed-value bundle between a PS/2 receiver and num_entry_fsm.
interface num_entry_fsm_if #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned VW     = 7
);
  logic                  Enable;
  logic [7:0]            data;
  logic                  data_en;
  logic                  set;
  logic [VW-1:0]         value;
  logic [2:0]            count;
  logic [7*DIGITS-1:0]   HEX;

  modport master (output Enable, data, data_en, input set, value, count, HEX);
  modport slave  (input Enable, data, data_en, output set, value, count, HEX);
endinterface

// File: rtl/num_entry_fsm_sevenseg.sv
// One BCD digit to an active-low seven-segment pattern {g,f,e,d,c,b,a}; non-decimal codes blank.
module sevenseg (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h7F;
    case (bcd_i)
      4'd0: seg_o = 7'h40;
      4'd1: seg_o = 7'h79;
      4'd2: seg_o = 7'h24;
      4'd3: seg_o = 7'h30;
      4'd4: seg_o = 7'h19;
      4'd5: seg_o = 7'h12;
      4'd6: seg_o = 7'h02;
      4'd7: seg_o = 7'h78;
      4'd8: seg_o = 7'h00;
      4'd9: seg_o = 7'h10;
      default: seg_o = 7'h7F;
    endcase
  end
endmodule

// File: rtl/num_entry_fsm.sv
// PS/2 decimal number entry with backspace/escape, clamped commit and HEX echo.
// Define NUM_ENTRY_KEYPAD_EN to accept numeric-keypad digits and keypad ENTER.
module num_entry_fsm
  import num_entry_pkg::*;
#(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned MIN_VAL   = 1,
  parameter int unsigned MAX_VAL   = 99,
  parameter int unsigned RESET_VAL = 1
) (
  input  logic            Clock,
  input  logic            nReset,
  num_entry_fsm_if.slave  bus
);

  localparam int unsigned BW   = 4 * DIGITS;
  localparam int unsigned VW   = $clog2(MAX_VAL + 1);
  localparam int unsigned BINW = 14;

  localparam logic [BW-1:0]   MIN_BCD   = BW'(to_bcd(MIN_VAL));
  localparam logic [BW-1:0]   MAX_BCD   = BW'(to_bcd(MAX_VAL));
  localparam logic [BW-1:0]   RESET_BCD = BW'(to_bcd(RESET_VAL));
  localparam logic [2:0]      MIN_CNT   = 3'(sig_digits(MIN_VAL));
  localparam logic [2:0]      MAX_CNT   = 3'(sig_digits(MAX_VAL));
  localparam logic [2:0]      RESET_CNT = 3'(sig_digits(RESET_VAL));
  localparam logic [BINW-1:0] MIN_B     = BINW'(MIN_VAL);
  localparam logic [BINW-1:0] MAX_B     = BINW'(MAX_VAL);
  localparam logic [2:0]      FULL_CNT  = 3'(DIGITS);

`ifdef NUM_ENTRY_KEYPAD_EN
  localparam logic KEYPAD_EN = 1'b1;
`else
  localparam logic KEYPAD_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic            brk_q, brk_d;
  logic            ext_q, ext_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [BW-1:0]   shd_q, shd_d;
  logic [2:0]      shd_cnt_q, shd_cnt_d;
  logic [VW-1:0]   value_q, value_d;
  logic            set_q, set_d;

  logic            accept_c;
  digit_t          dig_c;
  logic            is_digit_c, is_enter_c, is_bksp_c, is_esc_c;
  logic [BINW-1:0] bin_c, cl_val_c;
  logic [BW-1:0]   cl_buf_c;
  logic [2:0]      cl_cnt_c;

  // Extended (E0-prefixed) bytes only matter as keypad ENTER.
  assign accept_c   = bus.Enable && bus.data_en;
  assign dig_c      = scan_to_digit(bus.data, KEYPAD_EN);
  assign is_digit_c = dig_c.valid && !ext_q;
  assign is_bksp_c  = (bus.data == SC_BKSP) && !ext_q;
  assign is_esc_c   = (bus.data == SC_ESC) && !ext_q;
  assign is_enter_c = (bus.data == SC_ENTER) && (!ext_q || KEYPAD_EN);

  // BCD buffer to binary (unused upper digits are always zero) and clamp.
  always_comb begin
    bin_c = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      bin_c = BINW'(bin_c * BINW'(10)) + BINW'(buf_q[4*k +: 4]);
    end
    cl_val_c = bin_c;
    cl_buf_c = buf_q;
    cl_cnt_c = cnt_q;
    if (bin_c < MIN_B) begin
      cl_val_c = MIN_B;
      cl_buf_c = MIN_BCD;
      cl_cnt_c = MIN_CNT;
    end else if (bin_c > MAX_B) begin
      cl_val_c = MAX_B;
      cl_buf_c = MAX_BCD;
      cl_cnt_c = MAX_CNT;
    end
  end

  always_comb begin
    state_d   = state_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    shd_d     = shd_q;
    shd_cnt_d = shd_cnt_q;
    value_d   = value_q;
    set_d     = set_q;

    if (accept_c) begin
      if (brk_q) begin
        // Byte after F0 is a key release: swallow it.
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (bus.data == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (bus.data == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (is_digit_c) begin
              buf_d   = BW'(dig_c.digit);
              cnt_d   = 3'd1;
              set_d   = 1'b0;
              state_d = ST_ENTRY;
            end
          end
          ST_ENTRY: begin
            if (is_digit_c) begin
              if (cnt_q < FULL_CNT) begin
                buf_d = BW'({buf_q, dig_c.digit});
                cnt_d = cnt_q + 3'd1;
              end
            end else if (is_bksp_c) begin
              if (cnt_q != 3'd0) begin
                buf_d = buf_q >> 4;
                cnt_d = cnt_q - 3'd1;
              end
            end else if (is_enter_c) begin
              if (cnt_q != 3'd0) begin
                value_d   = VW'(cl_val_c);
                buf_d     = cl_buf_c;
                cnt_d     = cl_cnt_c;
                shd_d     = cl_buf_c;
                shd_cnt_d = cl_cnt_c;
              end else begin
                buf_d = shd_q;
                cnt_d = shd_cnt_q;
              end
              set_d   = 1'b1;
              state_d = ST_IDLE;
            end else if (is_esc_c) begin
              buf_d   = shd_q;
              cnt_d   = shd_cnt_q;
              set_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      buf_q     <= RESET_BCD;
      cnt_q     <= RESET_CNT;
      shd_q     <= RESET_BCD;
      shd_cnt_q <= RESET_CNT;
      value_q   <= VW'(RESET_VAL);
      set_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      shd_q     <= shd_d;
      shd_cnt_q <= shd_cnt_d;
      value_q   <= value_d;
      set_q     <= set_d;
    end
  end

  logic [7*DIGITS-1:0] hex_c;

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_seg
    sevenseg u_seg (
      .bcd_i (buf_q[4*k +: 4]),
      .seg_o (hex_c[7*k +: 7])
    );
  end

  assign bus.set   = set_q;
  assign bus.value = value_q;
  assign bus.count = cnt_q;
  assign bus.HEX   = hex_c;

endmodule

// File: tb/tb_num_entry_fsm.sv
// Table-driven scoreboard bench for num_entry_fsm (DIGITS=3, range 1..255, reset 1).
module tb_num_entry_fsm;

  typedef struct {
    bit         en;
    logic [7:0] sc;
    bit         set;
    logic [7:0] val;
    logic [2:0] cnt;
    logic [11:0] bcd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  vec_t vecs[$];
  vec_t sb_q[$];

  num_entry_fsm_if #(.DIGITS(3), .VW(8)) bus ();

  num_entry_fsm #(
    .DIGITS(3), .MIN_VAL(1), .MAX_VAL(255), .RESET_VAL(1)
  ) dut (
    .Clock  (clk),
    .nReset (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare(input vec_t e, input string tag);
    logic [20:0] hx;
    hx = {seg(e.bcd[11:8]), seg(e.bcd[7:4]), seg(e.bcd[3:0])};
    check({tag, ".set"},   32'(bus.set),   32'(e.set));
    check({tag, ".value"}, 32'(bus.value), 32'(e.val));
    check({tag, ".count"}, 32'(bus.count), 32'(e.cnt));
    check({tag, ".HEX"},   32'(bus.HEX),   32'(hx));
  endtask

  task automatic add(input bit en, input logic [7:0] sc, input bit s,
                     input logic [7:0] v, input logic [2:0] c, input logic [11:0] b);
    vec_t t;
    t.en = en; t.sc = sc; t.set = s; t.val = v; t.cnt = c; t.bcd = b;
    vecs.push_back(t);
  endtask

  // Drive one strobed byte, then compare the state the following edge produced.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    bus.Enable  = v.en;
    bus.data    = v.sc;
    bus.data_en = 1'b1;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    bus.data_en = 1'b0;
    bus.Enable  = 1'b1;
    e = sb_q.pop_front();
    compare(e, tag);
  endtask

  initial begin
    vec_t  rv;
    logic [7:0] kv;

    rst_n       = 1'b0;
    bus.Enable  = 1'b0;
    bus.data    = 8'h00;
    bus.data_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rv.en = 1'b1; rv.sc = 8'h00; rv.set = 1'b1; rv.val = 8'd1; rv.cnt = 3'd1; rv.bcd = 12'h001;
    compare(rv, "reset");
    @(negedge clk);
    rst_n      = 1'b1;
    bus.Enable = 1'b1;

    // 1,2,8 with releases, ENTER -> 128
    add(1, 8'h16, 0, 8'd1,   3'd1, 12'h001);
    add(1, 8'hF0, 0, 8'd1,   3'd1, 12'h001);
    add(1, 8'h16, 0, 8'd1,   3'd1, 12'h001);
    add(1, 8'h1E, 0, 8'd1,   3'd2, 12'h012);
    add(1, 8'hF0, 0, 8'd1,   3'd2, 12'h012);
    add(1, 8'h1E, 0, 8'd1,   3'd2, 12'h012);
    add(1, 8'h3E, 0, 8'd1,   3'd3, 12'h128);
    add(1, 8'hF0, 0, 8'd1,   3'd3, 12'h128);
    add(1, 8'h3E, 0, 8'd1,   3'd3, 12'h128);
    add(1, 8'h5A, 1, 8'd128, 3'd3, 12'h128);
    add(1, 8'hF0, 1, 8'd128, 3'd3, 12'h128);
    add(1, 8'h5A, 1, 8'd128, 3'd3, 12'h128);
    // 9,9,9,(9 ignored) ENTER clamps to 255; 0 ENTER clamps to 1
    add(1, 8'h46, 0, 8'd128, 3'd1, 12'h009);
    add(1, 8'h46, 0, 8'd128, 3'd2, 12'h099);
    add(1, 8'h46, 0, 8'd128, 3'd3, 12'h999);
    add(1, 8'h46, 0, 8'd128, 3'd3, 12'h999);
    add(1, 8'h5A, 1, 8'd255, 3'd3, 12'h255);
    add(1, 8'h45, 0, 8'd255, 3'd1, 12'h000);
    add(1, 8'h5A, 1, 8'd1,   3'd1, 12'h001);
    // 4,5,6,7 -> 456; backspace; ESC restores shadow
    add(1, 8'h25, 0, 8'd1,   3'd1, 12'h004);
    add(1, 8'h2E, 0, 8'd1,   3'd2, 12'h045);
    add(1, 8'h36, 0, 8'd1,   3'd3, 12'h456);
    add(1, 8'h3D, 0, 8'd1,   3'd3, 12'h456);
    add(1, 8'h66, 0, 8'd1,   3'd2, 12'h045);
    add(1, 8'h76, 1, 8'd1,   3'd1, 12'h001);
    // IDLE ignores ESC, backspace, unknown keys, ENTER
    add(1, 8'h76, 1, 8'd1,   3'd1, 12'h001);
    add(1, 8'h66, 1, 8'd1,   3'd1, 12'h001);
    add(1, 8'h1C, 1, 8'd1,   3'd1, 12'h001);
    add(1, 8'h5A, 1, 8'd1,   3'd1, 12'h001);
    // Enable low: key ignored, and pending break flag not consumed
    add(0, 8'h2E, 1, 8'd1,   3'd1, 12'h001);
    add(1, 8'hF0, 1, 8'd1,   3'd1, 12'h001);
    add(0, 8'h16, 1, 8'd1,   3'd1, 12'h001);
    add(1, 8'h16, 1, 8'd1,   3'd1, 12'h001);
    add(1, 8'h16, 0, 8'd1,   3'd1, 12'h001);
    // Backspace to empty, ENTER on empty restores shadow
    add(1, 8'h66, 0, 8'd1,   3'd0, 12'h000);
    add(1, 8'h66, 0, 8'd1,   3'd0, 12'h000);
    add(1, 8'h5A, 1, 8'd1,   3'd1, 12'h001);
    // Leading zero kept as a digit in buffer and shadow
    add(1, 8'h45, 0, 8'd1,   3'd1, 12'h000);
    add(1, 8'h3E, 0, 8'd1,   3'd2, 12'h008);
    add(1, 8'h5A, 1, 8'd8,   3'd2, 12'h008);
    add(1, 8'h2E, 0, 8'd8,   3'd1, 12'h005);
    add(1, 8'h76, 1, 8'd8,   3'd2, 12'h008);
    // Extended prefix suppresses the next byte; E0 F0 x also swallowed
    add(1, 8'hE0, 1, 8'd8,   3'd2, 12'h008);
    add(1, 8'h16, 1, 8'd8,   3'd2, 12'h008);
    add(1, 8'h16, 0, 8'd8,   3'd1, 12'h001);
    add(1, 8'h1C, 0, 8'd8,   3'd1, 12'h001);
    add(1, 8'hE0, 0, 8'd8,   3'd1, 12'h001);
    add(1, 8'h66, 0, 8'd8,   3'd1, 12'h001);
    add(1, 8'hE0, 0, 8'd8,   3'd1, 12'h001);
    add(1, 8'hF0, 0, 8'd8,   3'd1, 12'h001);
    add(1, 8'h16, 0, 8'd8,   3'd1, 12'h001);
    add(1, 8'h76, 1, 8'd8,   3'd2, 12'h008);
`ifdef NUM_ENTRY_KEYPAD_EN
    add(1, 8'h72, 0, 8'd8,   3'd1, 12'h002);
    add(1, 8'h70, 0, 8'd8,   3'd2, 12'h020);
    add(1, 8'hE0, 0, 8'd8,   3'd2, 12'h020);
    add(1, 8'h5A, 1, 8'd20,  3'd2, 12'h020);
    kv = 8'd20;
`else
    add(1, 8'h72, 1, 8'd8,   3'd2, 12'h008);
    add(1, 8'h70, 1, 8'd8,   3'd2, 12'h008);
    add(1, 8'hE0, 1, 8'd8,   3'd2, 12'h008);
    add(1, 8'h5A, 1, 8'd8,   3'd2, 12'h008);
    kv = 8'd8;
`endif

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Mid-entry asynchronous reset discards the edit and the committed value
    rv.en = 1'b1; rv.sc = 8'h25; rv.set = 1'b0; rv.val = kv; rv.cnt = 3'd1; rv.bcd = 12'h004;
    apply(rv, "rst_pre0");
    rv.sc = 8'h2E; rv.cnt = 3'd2; rv.bcd = 12'h045;
    apply(rv, "rst_pre1");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    rv.set = 1'b1; rv.val = 8'd1; rv.cnt = 3'd1; rv.bcd = 12'h001;
    compare(rv, "rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    // Back in IDLE: a digit starts a fresh entry rather than extending 45
    rv.sc = 8'h36; rv.set = 1'b0; rv.val = 8'd1; rv.cnt = 3'd1; rv.bcd = 12'h006;
    apply(rv, "rst_post");
    rv.sc = 8'h76; rv.set = 1'b1; rv.cnt = 3'd1; rv.bcd = 12'h001;
    apply(rv, "rst_esc");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/num_entry_fsm.md
NUM_ENTRY_FSM -- requirements
Module: num_entry_fsm

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of decimal digits accepted (legal 1..4).
REQ-002 SHALL have parameter MIN_VAL, default 1, lowest committable value.
REQ-003 SHALL have parameter MAX_VAL, default 99, highest committable value (MIN_VAL <= MAX_VAL <= 10^DIGITS-1).
REQ-004 SHALL have parameter RESET_VAL, default 1, committed value after reset (MIN_VAL..MAX_VAL).
REQ-005 SHALL have port Clock  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port nReset  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port Enable  in  1  high = process bytes; low = hold all state, ignore data.
REQ-008 SHALL have port data  in  8  PS/2 scancode byte.
REQ-009 SHALL have port data_en  in  1  one-cycle strobe, data valid.
REQ-010 SHALL have port set  out  1  high = value committed, no edit pending.
REQ-011 SHALL have port value  out  VW  committed binary value, VW = clog2(MAX_VAL+1).
REQ-012 SHALL have port count  out  3  digits in entry buffer (0..DIGITS).
REQ-013 SHALL have port HEX  out  7*DIGITS  seven-segment of entry buffer, digit k at [7k+6:7k], k=0 ones.

Function
REQ-014 SHALL accept a byte only when Enable && data_en; otherwise all registers hold.
REQ-015 SHALL drop F0 and set a break flag; the next accepted byte SHALL be discarded and clear the flag (key releases never act).
REQ-016 SHALL drop E0 and set an extended flag, cleared by the next non-F0 byte; extended bytes SHALL be ignored except keypad enter (E0 5A) when enabled (REQ-029).
REQ-017 SHALL implement states IDLE and ENTRY; reset to IDLE.
REQ-018 Digit key in IDLE: buffer = {0..0,d}, count=1, set<=0, go ENTRY.
REQ-019 Digit key in ENTRY with count<DIGITS: buffer shifts left one BCD digit, d into ones, count+1; count==DIGITS: ignored.
REQ-020 BACKSPACE (66) in ENTRY: buffer shifts right, zero into top, count-1; count reaching 0 stays in ENTRY; in IDLE ignored.
REQ-021 ENTER (5A) in ENTRY with count>=1: binary = sum of BCD*10^k, clamped to [MIN_VAL,MAX_VAL], registered into value, set<=1, go IDLE on same edge (value visible cycle after strobe).
REQ-022 On clamp, buffer SHALL load MIN_BCD/MAX_BCD (elaboration-time constants) and count=number of significant digits, so HEX shows the committed value.
REQ-023 ENTER with count==0: value unchanged, buffer restored from shadow, set<=1, go IDLE.
REQ-024 ESC (76) in ENTRY: buffer and count restored from shadow (last committed BCD), set<=1, go IDLE; IDLE ignores ESC.
REQ-025 Shadow BCD SHALL update only on commit; leading zeros entered count as digits.
REQ-026 Any other scancode SHALL be ignored without state change.

Reset
REQ-027 nReset low SHALL asynchronously force: IDLE, flags 0, value=RESET_VAL, set=1, buffer=shadow=RESET_BCD, count=significant digits of RESET_VAL (min 1); reset mid-entry discards the edit.

Configuration
REQ-028 Macro NUM_ENTRY_KEYPAD_EN SHALL gate numeric-keypad support.
REQ-029 Defined: keypad digits 70,69,72,7A,6B,73,74,6C,75,7D (0..9) act as digits, E0 5A acts as ENTER; undefined: those bytes ignored.

Structure
REQ-030 Shared package num_entry_pkg SHALL hold scancode constants, state encodings and the scancode-to-digit function.
REQ-031 Sub-module sevenseg SHALL be instantiated DIGITS times for HEX; BCD-to-binary and clamp stay inline.

Verification (DIGITS=3, MIN_VAL=1, MAX_VAL=255, RESET_VAL=1)
REQ-032 Reset -> value=1, set=1, count=1, HEX0 shows 1.
REQ-033 Keys 1,2,8,ENTER (each followed by F0,key) -> value=128, set=1 cycle after ENTER, released bytes cause no change.
REQ-034 Keys 9,9,9,ENTER -> value=255, HEX shows 255; keys 0,ENTER -> value=1.
REQ-035 Keys 4,5,6,7 -> count=3, buffer 456; BACKSPACE -> 45; ESC -> buffer 1 (shadow), value unchanged, set=1.
REQ-036 Enable=0 with key 5 strobed -> no change; mid-entry nReset pulse -> IDLE, value=1.
REQ-037 With NUM_ENTRY_KEYPAD_EN: 72,70,E0 5A -> value=20; without: value unchanged, set=1.
